// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO interrupt peripheral.
package gpio_pkg;

  localparam int unsigned MAX_PINS = 32;
  localparam int unsigned WORD_W   = 3;

  // Register word indices, decoded from addr_i[4:2]
  localparam logic [WORD_W-1:0] GPIO_DIR      = 3'd0;
  localparam logic [WORD_W-1:0] GPIO_DATA_OUT = 3'd1;
  localparam logic [WORD_W-1:0] GPIO_DATA_IN  = 3'd2;
  localparam logic [WORD_W-1:0] GPIO_IRQ_EN   = 3'd3;
  localparam logic [WORD_W-1:0] GPIO_RISE_EN  = 3'd4;
  localparam logic [WORD_W-1:0] GPIO_FALL_EN  = 3'd5;
  localparam logic [WORD_W-1:0] GPIO_PEND     = 3'd6;

endpackage

// File: rtl/gpio_sync_edge.sv
// Multi-stage input synchroniser with one history flop and edge outputs.
module gpio_sync_edge #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise_c,
  output logic [WIDTH-1:0] fall_c
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;
  logic [WIDTH-1:0]             prev_q;

  // Shift the asynchronous input through the chain, then keep one cycle of history
  always_ff @(posedge clk) begin
    if (!rst) begin
      stage_q <= '0;
      prev_q  <= '0;
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      prev_q <= stage_q[STAGES-1];
    end
  end

  assign sync   = stage_q[STAGES-1];
  assign rise_c = sync & ~prev_q;
  assign fall_c = ~sync & prev_q;

endmodule

// File: rtl/gpio_irq.sv
// Bidirectional GPIO block with per-pin edge interrupts and a W1C pending register.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int unsigned NUM_PINS    = 2,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                we_i,
  input  logic                sel_i,
  input  logic                enable_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  output logic [15:0]         HSPLIT,
  output logic [31:0]         data_o,
  output logic                ack_o,
  output logic [NUM_PINS-1:0] io_out,
  output logic [NUM_PINS-1:0] io_oe,
  input  logic [NUM_PINS-1:0] io_in,
  output logic                irq_o
);

  localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
  localparam int unsigned ARM_W   = $clog2(ARM_MAX + 1);

  if (NUM_PINS < 1 || NUM_PINS > MAX_PINS) begin : g_bad_pins
    $error("gpio_irq: NUM_PINS out of range");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("gpio_irq: SYNC_STAGES must be at least 2");
  end

  logic [NUM_PINS-1:0] dir_q, out_q, irq_en_q, rise_en_q, fall_en_q, pend_q;
  logic [NUM_PINS-1:0] pend_set, pend_clr;
  logic [NUM_PINS-1:0] sync, rise, fall;
  logic [ARM_W-1:0]    arm_cnt_q;
  logic                armed;
  logic                wr, rd;
  logic [WORD_W-1:0]   word;
  logic [31:0]         rdata;
  logic                unused_bits;

  assign HSPLIT = 16'h0;
  assign ack_o  = 1'b1;
  assign io_out = out_q;
  assign io_oe  = dir_q;

  assign word = addr_i[4:2];
  assign wr   = sel_i & we_i & enable_i;
  assign rd   = sel_i & ~we_i & enable_i & rst;

  assign unused_bits = ^{addr_i[31:5], addr_i[1:0], data_i};

  gpio_sync_edge #(
    .WIDTH  (NUM_PINS),
    .STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (io_in),
    .sync   (sync),
    .rise_c (rise),
    .fall_c (fall)
  );

  // Edge detection is held off until the synchroniser has flushed its reset zeros
  assign armed = (arm_cnt_q == ARM_W'(ARM_MAX));

  // A newly detected edge takes priority over a same-cycle W1C
  always_comb begin
    pend_set = '0;
    pend_clr = '0;
    if (armed) begin
      pend_set = (rise & rise_en_q) | (fall & fall_en_q);
    end
    if (wr && word == GPIO_PEND) begin
      pend_clr = data_i[NUM_PINS-1:0];
    end
  end

  // Software-visible registers, pending bits and arm counter
  always_ff @(posedge clk) begin
    if (!rst) begin
      dir_q     <= '0;
      out_q     <= '0;
      irq_en_q  <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      pend_q    <= '0;
      arm_cnt_q <= '0;
    end else begin
      if (wr) begin
        case (word)
          GPIO_DIR:      dir_q     <= data_i[NUM_PINS-1:0];
          GPIO_DATA_OUT: out_q     <= data_i[NUM_PINS-1:0];
          GPIO_IRQ_EN:   irq_en_q  <= data_i[NUM_PINS-1:0];
          GPIO_RISE_EN:  rise_en_q <= data_i[NUM_PINS-1:0];
          GPIO_FALL_EN:  fall_en_q <= data_i[NUM_PINS-1:0];
          default: ;
        endcase
      end
      pend_q <= (pend_q & ~pend_clr) | pend_set;
      if (!armed) begin
        arm_cnt_q <= arm_cnt_q + ARM_W'(1);
      end
    end
  end

  // Read mux; unmapped words return zero
  always_comb begin
    rdata = '0;
    case (word)
      GPIO_DIR:      rdata = 32'(dir_q);
      GPIO_DATA_OUT: rdata = 32'(out_q);
      GPIO_DATA_IN:  rdata = 32'(sync);
      GPIO_IRQ_EN:   rdata = 32'(irq_en_q);
      GPIO_RISE_EN:  rdata = 32'(rise_en_q);
      GPIO_FALL_EN:  rdata = 32'(fall_en_q);
      GPIO_PEND:     rdata = 32'(pend_q);
      default:       rdata = '0;
    endcase
  end

  assign data_o = rd ? rdata : 32'h0;
  assign irq_o  = rst & (|(pend_q & irq_en_q));

endmodule

// File: tb/tb_gpio_irq.sv
// Directed bench for gpio_irq: register table plus interrupt timing sequences.
module tb_gpio_irq;

  localparam int unsigned N = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          we_i, sel_i, enable_i;
  logic [31:0]   addr_i, data_i;
  logic [15:0]   HSPLIT;
  logic [31:0]   data_o;
  logic          ack_o;
  logic [N-1:0]  io_out, io_oe, io_in;
  logic          irq_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpio_irq #(.NUM_PINS(N), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .we_i     (we_i),
    .sel_i    (sel_i),
    .enable_i (enable_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .HSPLIT   (HSPLIT),
    .data_o   (data_o),
    .ack_o    (ack_o),
    .io_out   (io_out),
    .io_oe    (io_oe),
    .io_in    (io_in),
    .irq_o    (irq_o)
  );

  typedef struct {
    logic        we, sel, en;
    logic [31:0] addr, wd;
    logic [N-1:0] io;
    logic [31:0] exp_data;
    logic [N-1:0] exp_out, exp_oe;
    logic        exp_irq;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic we, input logic sel, input logic en,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [N-1:0] io, input logic [31:0] ed,
                              input logic [N-1:0] eo, input logic [N-1:0] eoe,
                              input logic ei);
    vec_t v;
    v.we = we; v.sel = sel; v.en = en; v.addr = addr; v.wd = wd; v.io = io;
    v.exp_data = ed; v.exp_out = eo; v.exp_oe = eoe; v.exp_irq = ei;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic bus(input logic we, input logic sel, input logic en,
                     input logic [31:0] addr, input logic [31:0] wd);
    we_i = we; sel_i = sel; enable_i = en; addr_i = addr; data_i = wd;
  endtask

  task automatic idle();
    bus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    bus(1'b1, 1'b1, 1'b1, addr, d);
    tick(1);
    idle();
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus(1'b0, 1'b1, 1'b1, addr, 32'h0);
    @(negedge clk);
    check(name, data_o, exp);
    tick(1);
    idle();
  endtask

  task automatic irq_check(input string name, input logic exp);
    @(negedge clk);
    check(name, 32'(irq_o), 32'(exp));
  endtask

  initial begin
    rst = 1'b0;
    io_in = '0;
    idle();
    tick(3);
    @(negedge clk);
    check("reset_io_out", 32'(io_out), 32'h0);
    check("reset_io_oe", 32'(io_oe), 32'h0);
    check("reset_irq", 32'(irq_o), 32'h0);
    check("hsplit", 32'(HSPLIT), 32'h0);
    check("ack", 32'(ack_o), 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Register access table; expected outputs are those seen before the vector's clock edge
    tbl.push_back(mk(0,0,0, 32'h00, 32'h0,        2'b00, 32'h0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(1,1,1, 32'h04, 32'h3,        2'b00, 32'h0, 2'b00, 2'b00, 0));
    tbl.push_back(mk(1,1,1, 32'h00, 32'h3,        2'b00, 32'h0, 2'b11, 2'b00, 0));
    tbl.push_back(mk(0,1,1, 32'h04, 32'h0,        2'b00, 32'h3, 2'b11, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h00, 32'h0,        2'b00, 32'h3, 2'b11, 2'b11, 0));
    tbl.push_back(mk(1,1,1, 32'h1C, 32'hFFFFFFFF, 2'b00, 32'h0, 2'b11, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h04, 32'h0,        2'b00, 32'h3, 2'b11, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h1C, 32'h0,        2'b00, 32'h0, 2'b11, 2'b11, 0));
    tbl.push_back(mk(1,1,1, 32'h08, 32'h0,        2'b00, 32'h0, 2'b11, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h00, 32'h0,        2'b00, 32'h3, 2'b11, 2'b11, 0));
    tbl.push_back(mk(1,1,1, 32'h04, 32'hFFFFFFFE, 2'b00, 32'h0, 2'b11, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h04, 32'h0,        2'b00, 32'h2, 2'b10, 2'b11, 0));
    tbl.push_back(mk(0,0,1, 32'h04, 32'h0,        2'b00, 32'h0, 2'b10, 2'b11, 0));
    tbl.push_back(mk(0,1,0, 32'h04, 32'h0,        2'b00, 32'h0, 2'b10, 2'b11, 0));
    tbl.push_back(mk(1,1,1, 32'h0C, 32'hFFFFFFFF, 2'b00, 32'h0, 2'b10, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h0C, 32'h0,        2'b00, 32'h3, 2'b10, 2'b11, 0));
    tbl.push_back(mk(1,1,1, 32'h0C, 32'h0,        2'b00, 32'h0, 2'b10, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h0C, 32'h0,        2'b00, 32'h0, 2'b10, 2'b11, 0));
    tbl.push_back(mk(1,1,1, 32'h04, 32'h3,        2'b11, 32'h0, 2'b10, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h08, 32'h0,        2'b11, 32'h0, 2'b11, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h08, 32'h0,        2'b11, 32'h3, 2'b11, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h18, 32'h0,        2'b11, 32'h0, 2'b11, 2'b11, 0));
    tbl.push_back(mk(1,1,1, 32'h10, 32'h3,        2'b11, 32'h0, 2'b11, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h10, 32'h0,        2'b11, 32'h3, 2'b11, 2'b11, 0));
    tbl.push_back(mk(1,1,1, 32'h10, 32'h0,        2'b11, 32'h0, 2'b11, 2'b11, 0));
    tbl.push_back(mk(0,1,1, 32'h14, 32'h0,        2'b11, 32'h0, 2'b11, 2'b11, 0));

    foreach (tbl[i]) begin
      bus(tbl[i].we, tbl[i].sel, tbl[i].en, tbl[i].addr, tbl[i].wd);
      io_in = tbl[i].io;
      @(negedge clk);
      check($sformatf("tbl%0d_data", i), data_o, tbl[i].exp_data);
      check($sformatf("tbl%0d_out", i), 32'(io_out), 32'(tbl[i].exp_out));
      check($sformatf("tbl%0d_oe", i), 32'(io_oe), 32'(tbl[i].exp_oe));
      check($sformatf("tbl%0d_irq", i), 32'(irq_o), 32'(tbl[i].exp_irq));
      tick(1);
    end
    idle();

    // Rising edge on pin 0: PEND sets two edges after the sampling edge
    io_in = 2'b00;
    tick(4);
    wr(32'h10, 32'h1);
    wr(32'h0C, 32'h1);
    rd_check("rise_pend_idle", 32'h18, 32'h0);
    io_in = 2'b01;
    tick(1);
    irq_check("rise_irq_k", 1'b0);
    tick(1);
    irq_check("rise_irq_k1", 1'b0);
    tick(1);
    irq_check("rise_irq_k2", 1'b1);
    rd_check("rise_pend", 32'h18, 32'h1);
    wr(32'h18, 32'h1);
    irq_check("rise_irq_clr", 1'b0);
    rd_check("rise_pend_clr", 32'h18, 32'h0);

    // Falling edge on pin 1 with the interrupt masked, then unmasked
    wr(32'h0C, 32'h0);
    wr(32'h14, 32'h2);
    io_in = 2'b11;
    tick(4);
    rd_check("fall_pend_pre", 32'h18, 32'h0);
    io_in = 2'b01;
    tick(3);
    irq_check("fall_irq_masked", 1'b0);
    rd_check("fall_pend", 32'h18, 32'h2);
    wr(32'h0C, 32'h2);
    irq_check("fall_irq_unmasked", 1'b1);
    wr(32'h18, 32'h2);
    irq_check("fall_irq_clr", 1'b0);

    // W1C landing on the same edge as a new rise: the set wins
    io_in = 2'b00;
    tick(4);
    io_in = 2'b01;
    tick(2);
    wr(32'h18, 32'h1);
    rd_check("collide_pend", 32'h18, 32'h1);
    wr(32'h18, 32'h1);
    rd_check("collide_pend_clr", 32'h18, 32'h0);

    // Build PEND=0x3, then reset mid-operation with the pins held high
    wr(32'h10, 32'h3);
    wr(32'h0C, 32'h3);
    io_in = 2'b00;
    tick(4);
    io_in = 2'b11;
    tick(3);
    irq_check("both_irq", 1'b1);
    rd_check("both_pend", 32'h18, 32'h3);
    rst = 1'b0;
    bus(1'b0, 1'b1, 1'b1, 32'h18, 32'h0);
    tick(1);
    @(negedge clk);
    check("midrst_data", data_o, 32'h0);
    check("midrst_irq", 32'(irq_o), 32'h0);
    check("midrst_out", 32'(io_out), 32'h0);
    check("midrst_oe", 32'(io_oe), 32'h0);
    tick(1);
    rst = 1'b1;
    idle();

    // Pins high out of reset must not raise PEND during the arm window
    wr(32'h10, 32'h3);
    wr(32'h0C, 32'h3);
    tick(5);
    irq_check("arm_irq", 1'b0);
    rd_check("arm_pend", 32'h18, 32'h0);
    io_in = 2'b10;
    tick(4);
    io_in = 2'b11;
    tick(3);
    rd_check("post_arm_pend", 32'h18, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_irq.md
Name: gpio_irq

Overview:
- Parametrised successor to the fixed 2-bit output-only GPIO peripheral. Provides NUM_PINS bidirectional pins with a per-pin direction register and a synchronised input path.
- Adds per-pin rising/falling-edge interrupt detection, with a write-1-to-clear pending register and a single level interrupt output.
- Sits on the peripheral bus as a slave, using the same sel/we/enable strobe interface, HSPLIT tie-off and always-ready ack as the other peripherals.

Parameters:
- NUM_PINS, 2, number of GPIO pins; legal range 1..32.
- SYNC_STAGES, 2, input synchroniser depth; legal values >=2.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-low
- we_i  input  1  bus write strobe
- sel_i  input  1  slave select
- enable_i  input  1  bus access phase enable
- addr_i  input  32  byte address; only addr_i[4:2] is decoded
- data_i  input  32  write data
- HSPLIT  output  16  tied to 16'h0
- data_o  output  32  read data, combinational
- ack_o  output  1  tied to 1'b1 (zero wait states)
- io_out  output  NUM_PINS  pin output values (DATA_OUT)
- io_oe  output  NUM_PINS  pin output enables (DIR; 1 = drive)
- io_in  input  NUM_PINS  asynchronous pin inputs
- irq_o  output  1  level interrupt; high while |(PEND & IRQ_EN)

Behaviour:
- Reset: clk is the clock; rst is synchronous and active-low.
  - When rst==0 at a posedge, all registers and synchroniser flops clear to 0 and the arm counter clears.
  - Outputs during reset: io_out=0, io_oe=0, irq_o=0, data_o=0.
- Register map (word index = addr_i[4:2]); bits above NUM_PINS-1 read 0 and ignore writes.
  - 0x00 DIR, RW.
  - 0x04 DATA_OUT, RW. Legacy offset, so existing software that writes 0x4 still drives the pins.
  - 0x08 DATA_IN, RO: last synchroniser stage.
  - 0x0C IRQ_EN, RW.
  - 0x10 RISE_EN, RW.
  - 0x14 FALL_EN, RW.
  - 0x18 PEND, W1C: writing 1 clears a bit, writing 0 has no effect.
  - 0x1C: reads 0.
- Write: occurs when sel_i & we_i & enable_i is high at a posedge. The register updates at that edge, and the effect is visible on io_out/io_oe in the following cycle.
  - Writes to RO or unmapped offsets are ignored. Unlike the legacy block, they do NOT clear any register.
- Read: rd = sel_i & ~we_i & enable_i.
  - data_o is combinational: the zero-extended selected register when rd is high, otherwise 32'h0.
  - No latch is allowed; data_o is always fully assigned.
- Input path: io_in passes through SYNC_STAGES flops (sync), followed by one further flop (prev).
  - rise = sync & ~prev; fall = ~sync & prev.
- Edge-to-pending latency (SYNC_STAGES=2): a pin change that is sampled at posedge k sets PEND at posedge k+2. irq_o rises combinationally after that same edge.
- PEND set condition: PEND[i] sets when armed & ((rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i])).
  - PEND sets independently of IRQ_EN. IRQ_EN only masks irq_o.
- Arm counter: after reset release, a saturating counter gates edge detection until SYNC_STAGES+1 cycles have elapsed. This prevents spurious edges from pins that are high out of reset.
- Simultaneous W1C and new edge on the same bit in the same cycle: set wins, so PEND stays 1.
- Edges are not counted: several edges on one pin before a clear collapse into a single PEND bit.
- DIR does not gate the input path: a pin driven as an output still reads back and can still raise interrupts.
- Reset asserted mid-operation clears PEND and the counter immediately. A pending interrupt is lost by design.

Decomposition:
- Shared package gpio_pkg:
  - register offset constants GPIO_DIR, GPIO_DATA_OUT, GPIO_DATA_IN, GPIO_IRQ_EN, GPIO_RISE_EN, GPIO_FALL_EN, GPIO_PEND;
  - localparam MAX_PINS=32.
- One sub-module, gpio_sync_edge: a per-vector synchroniser plus prev flop, producing sync/rise/fall. It is parametrised by WIDTH and STAGES and is reusable by other peripherals.
- Top-level gpio_irq: bus decode, registers, PEND logic and arm counter.

Test Plan:
- Legacy compatibility: reset, write DATA_OUT (0x04) = 0x3 and DIR = 0x3 -> io_out=2'b11, io_oe=2'b11 one cycle after the write; reading 0x04 returns 0x00000003.
- Unmapped write: write 0x1C = 0xFFFFFFFF -> DATA_OUT unchanged (still 0x3); reading 0x1C returns 0.
- Rising edge interrupt: RISE_EN=0x1, IRQ_EN=0x1; io_in[0] goes 0->1 before posedge k -> PEND=0x1 and irq_o=1 after posedge k+2; writing PEND=0x1 -> irq_o=0 the next cycle.
- Masking and falling edge: FALL_EN=0x2, IRQ_EN=0; io_in[1] goes 1->0 -> PEND=0x2 with irq_o=0; then set IRQ_EN=0x2 -> irq_o=1.
- Set-wins collision: W1C of PEND[0] issued in the same cycle that a new rise on pin 0 is detected -> PEND[0] remains 1.
- Reset arm window: io_in=2'b11 held through reset with RISE_EN=0x3 written right after release -> PEND stays 0; mid-operation reset with PEND=0x3 -> PEND=0, irq_o=0, data_o=0.
